// File: rtl/stream_mux2_rr.sv
// Two-source round-robin stream merge into one registered output word tagged with its source index.
// Latency: one cycle. Backpressure: out_valid & !out_ready drops both input readys, and the held word stays stable.
module stream_mux2_rr #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i0_data,
    input  logic             i0_valid,
    output logic             i0_ready,
    input  logic [WIDTH-1:0] i1_data,
    input  logic             i1_valid,
    output logic             i1_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    typedef struct packed {
        logic             sel;
        logic [WIDTH-1:0] data;
    } word_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           state_nxt;
    word_t            word_q;
    word_t            word_nxt;
    logic             last_grant;
    logic             last_grant_nxt;
    logic             load;
    logic             grant;
    logic             take0;
    logic             take1;
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            word_q     <= '0;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            word_q     <= word_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    always_comb begin
        load           = (state == EMPTY) || out_ready;
        grant          = ~last_grant;
        state_nxt      = state;
        word_nxt       = word_q;
        last_grant_nxt = last_grant;

        // A lone requester always wins; a tie goes to whoever lost last time.
        if (i0_valid && i1_valid) begin
            grant = ~last_grant;
        end else if (i1_valid) begin
            grant = 1'b1;
        end else if (i0_valid) begin
            grant = 1'b0;
        end

        i0_ready = load && !grant && !rst;
        i1_ready = load &&  grant && !rst;
        take0    = i0_valid && i0_ready;
        take1    = i1_valid && i1_ready;

        if (take0) begin
            state_nxt      = FULL;
            word_nxt       = '{sel: 1'b0, data: i0_data};
            last_grant_nxt = 1'b0;
        end else if (take1) begin
            state_nxt      = FULL;
            word_nxt       = '{sel: 1'b1, data: i1_data};
            last_grant_nxt = 1'b1;
        end else if (load) begin
            state_nxt = EMPTY;
        end
    end

    // Statistics counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (take0 && (cnt0_q != CNT_MAX)) begin
                cnt0_q <= cnt0_q + 1'b1;
            end
            if (take1 && (cnt1_q != CNT_MAX)) begin
                cnt1_q <= cnt1_q + 1'b1;
            end
        end
    end

    assign out_valid = (state == FULL);
    assign out_data  = word_q.data;
    assign out_sel   = word_q.sel;
    assign cnt0      = cnt0_q;
    assign cnt1      = cnt1_q;

endmodule

// File: tb/tb_stream_mux2_rr.sv
// Bench for stream_mux2_rr: directed scenarios with literal expectations plus a randomized run,
// all checked every cycle against a rule-level model and per-source ordering queues.
module tb_stream_mux2_rr;

    localparam int WIDTH   = 8;
    localparam int CNT_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] i0_data;
    logic             i0_valid;
    logic             i0_ready;
    logic [WIDTH-1:0] i1_data;
    logic             i1_valid;
    logic             i1_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_sel;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    stream_mux2_rr #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .i0_data   (i0_data),
        .i0_valid  (i0_valid),
        .i0_ready  (i0_ready),
        .i1_data   (i1_data),
        .i1_valid  (i1_valid),
        .i1_ready  (i1_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cnt0      (cnt0),
        .cnt1      (cnt1)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: what the output register must hold, who lost the last tie,
    // and the words each source has had accepted but not yet delivered.
    logic             seen_rst = 1'b0;
    logic             m_vld;
    logic [WIDTH-1:0] m_data;
    logic             m_sel;
    logic             m_last;
    int               m_cnt0;
    int               m_cnt1;
    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    logic             ld;
    logic             g;
    logic [WIDTH-1:0] exp_w;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_i0_ready", int'(i0_ready), 0);
            chk("rst_i1_ready", int'(i1_ready), 0);
            seen_rst = 1'b1;
            m_vld    = 1'b0;
            m_data   = '0;
            m_sel    = 1'b0;
            m_last   = 1'b1;
            m_cnt0   = 0;
            m_cnt1   = 0;
            q0.delete();
            q1.delete();
        end else if (seen_rst) begin
            chk("out_valid", int'(out_valid), int'(m_vld));
            if (m_vld) begin
                chk("out_data", int'(out_data), int'(m_data));
                chk("out_sel", int'(out_sel), int'(m_sel));
            end
            chk("cnt0", int'(cnt0), m_cnt0);
            chk("cnt1", int'(cnt1), m_cnt1);

            ld = !m_vld || out_ready;
            if (i0_valid && i1_valid) g = !m_last;
            else                      g = i1_valid;
            if (i0_valid) chk("i0_ready", int'(i0_ready), int'(ld && !g));
            if (i1_valid) chk("i1_ready", int'(i1_ready), int'(ld && g));

            if (m_vld && out_ready) begin
                if (m_sel == 1'b0 && q0.size() > 0) begin
                    exp_w = q0.pop_front();
                    chk("order_src0", int'(out_data), int'(exp_w));
                end else if (m_sel == 1'b1 && q1.size() > 0) begin
                    exp_w = q1.pop_front();
                    chk("order_src1", int'(out_data), int'(exp_w));
                end else begin
                    chk("delivered_without_accept", 1, 0);
                end
            end

            if (ld && i0_valid && !g) begin
                m_vld  = 1'b1;
                m_data = i0_data;
                m_sel  = 1'b0;
                m_last = 1'b0;
                if (m_cnt0 < CNT_MAX) m_cnt0++;
                q0.push_back(i0_data);
            end else if (ld && i1_valid && g) begin
                m_vld  = 1'b1;
                m_data = i1_data;
                m_sel  = 1'b1;
                m_last = 1'b1;
                if (m_cnt1 < CNT_MAX) m_cnt1++;
                q1.push_back(i1_data);
            end else if (ld) begin
                m_vld = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        i0_valid = 1'b0;
        i1_valid = 1'b0;
        step();
        rst = 1'b0;
    endtask

    logic [WIDTH-1:0] seq[3] = '{8'h11, 8'h22, 8'h33};
    logic             acc0;
    logic             acc1;

    initial begin
        rst       = 1'b1;
        i0_valid  = 1'b1;
        i1_valid  = 1'b1;
        i0_data   = 8'hE0;
        i1_data   = 8'hE1;
        out_ready = 1'b1;

        // Reset held two cycles with both sources requesting.
        step();
        chk("rst_hold_i0_ready", int'(i0_ready), 0);
        chk("rst_hold_i1_ready", int'(i1_ready), 0);
        step();
        rst      = 1'b0;
        i0_valid = 1'b0;
        i1_valid = 1'b0;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_sel", int'(out_sel), 0);
        chk("rst_cnt0", int'(cnt0), 0);
        chk("rst_cnt1", int'(cnt1), 0);

        // Single source, back-to-back words.
        i0_valid = 1'b1;
        i0_data  = seq[0];
        for (int k = 0; k < 3; k++) begin
            step();
            chk("single_data", int'(out_data), int'(seq[k]));
            chk("single_sel", int'(out_sel), 0);
            chk("single_valid", int'(out_valid), 1);
            if (k < 2) i0_data = seq[k+1];
            else       i0_valid = 1'b0;
        end
        step();
        chk("single_cnt0", int'(cnt0), 3);
        chk("single_cnt1", int'(cnt1), 0);
        chk("single_drained", int'(out_valid), 0);

        // Continuous tie alternates starting with source 0.
        do_reset();
        i0_valid = 1'b1;
        i0_data  = 8'hA0;
        i1_valid = 1'b1;
        i1_data  = 8'hB0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("tie_sel", int'(out_sel), k % 2);
            chk("tie_data", int'(out_data), (k % 2 == 0) ? 32'hA0 : 32'hB0);
        end
        chk("tie_cnt0", int'(cnt0), 2);
        chk("tie_cnt1", int'(cnt1), 2);
        i0_valid = 1'b0;
        i1_valid = 1'b0;
        step();

        // Backpressure holds the word and blocks both inputs.
        do_reset();
        out_ready = 1'b0;
        i1_valid  = 1'b1;
        i1_data   = 8'h5A;
        step();
        i1_data  = 8'h77;
        i0_valid = 1'b1;
        i0_data  = 8'h3C;
        repeat (3) begin
            #1;
            chk("bp_data", int'(out_data), 32'h5A);
            chk("bp_sel", int'(out_sel), 1);
            chk("bp_i0_ready", int'(i0_ready), 0);
            chk("bp_i1_ready", int'(i1_ready), 0);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_i0_ready", int'(i0_ready), 1);
        chk("bp_release_i1_ready", int'(i1_ready), 0);
        step();
        chk("bp_next_data", int'(out_data), 32'h3C);
        chk("bp_next_sel", int'(out_sel), 0);
        i0_valid = 1'b0;
        step();
        chk("bp_then_src1", int'(out_data), 32'h77);
        i1_valid = 1'b0;
        step();
        chk("bp_empty", int'(out_valid), 0);

        // Counter saturation on source 1.
        do_reset();
        i1_valid = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            i1_data = 8'(8'h40 + k);
            step();
            chk("sat_data", int'(out_data), 32'h40 + k);
            chk("sat_cnt1", int'(cnt1), (k < CNT_MAX) ? k : CNT_MAX);
        end
        i1_valid = 1'b0;
        step();

        // Reset while a word is held; tie afterwards must favour source 0 again.
        do_reset();
        out_ready = 1'b0;
        i0_valid  = 1'b1;
        i0_data   = 8'h66;
        step();
        chk("mid_loaded", int'(out_valid), 1);
        i1_valid = 1'b1;
        rst      = 1'b1;
        step();
        chk("mid_out_valid", int'(out_valid), 0);
        chk("mid_cnt0", int'(cnt0), 0);
        rst       = 1'b0;
        out_ready = 1'b1;
        i0_data   = 8'h0A;
        i1_data   = 8'h0B;
        #1;
        chk("mid_tie_i0_ready", int'(i0_ready), 1);
        chk("mid_tie_i1_ready", int'(i1_ready), 0);
        step();
        chk("mid_tie_sel", int'(out_sel), 0);
        chk("mid_tie_data", int'(out_data), 32'h0A);
        i0_valid = 1'b0;
        i1_valid = 1'b0;
        step();

        // Randomized traffic; sources only change a word once it has been taken.
        repeat (3000) begin
            @(negedge clk);
            acc0 = i0_valid && i0_ready;
            acc1 = i1_valid && i1_ready;
            @(posedge clk);
            #1;
            if (!i0_valid || acc0) begin
                i0_valid = ($urandom_range(0, 3) != 0);
                i0_data  = 8'($urandom);
            end
            if (!i1_valid || acc1) begin
                i1_valid = ($urandom_range(0, 2) != 0);
                i1_data  = 8'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 199) == 0);
        end

        rst      = 1'b0;
        i0_valid = 1'b0;
        i1_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
